logic_issue_stage: RTL
======================

Name: logic_issue_stage

Overview:
- Producer side of the integer logic unit. Decodes RV32I logic, shift and CSR set/clear instructions into the logic unit's operand pair and its 8-bit one-hot select code.
- Registers the decoded result in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between register-file read and the logic unit. Sustains one instruction per cycle with fully registered outputs.

Parameters:
- WIDTH, 32, datapath width of operands. Decode logic is defined for 32 only.

Ports:
- clk_i  input  1  clock; all state on rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- flush_i  input  1  synchronous pipeline flush
- valid_i  input  1  upstream instruction valid
- ready_o  output  1  stage can accept an instruction
- instr_i  input  32  instruction word
- rs1_data_i  input  WIDTH  rs1 register value
- rs2_data_i  input  WIDTH  rs2 register value
- csr_rdata_i  input  WIDTH  current CSR value, for SYSTEM instructions
- valid_o  output  1  decoded entry valid
- ready_i  input  1  logic unit accepts entry
- op1_o  output  WIDTH  operand 1
- op2_o  output  WIDTH  operand 2
- sel_o  output  8  one-hot operation select
- rd_o  output  5  destination register, instr[11:7]
- csr_addr_o  output  12  instr[31:20]; meaningful for CSR ops only
- illegal_o  output  1  entry is not a supported instruction

Behaviour:
- Decode, from opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]. The input side is combinational; the decoded fields are captured on accept.
- OP (0110011), f7 = 0000000, with op1 = rs1, op2 = rs2:
  - f3=111 AND sel 0x01; f3=110 OR 0x02; f3=001 SLL 0x04; f3=101 SRL 0x08; f3=100 XOR 0x20.
- OP (0110011), f7 = 0100000, f3=101: SRA 0x10.
- OP-IMM (0010011), op1 = rs1:
  - ANDI/ORI/XORI (f3 111/110/100): op2 = sign-extended instr[31:20].
  - SLLI (f3=001, f7=0): op2 = {27'b0, instr[24:20]}.
  - SRLI/SRAI (f3=101, f7 = 0000000 / 0100000): op2 = {27'b0, instr[24:20]}.
- SYSTEM (1110011), op1 = csr_rdata_i:
  - CSRRS (f3=010) sel 0x40, CSRRC (f3=011) sel 0x80; op2 = rs1.
  - CSRRSI (f3=110) 0x40, CSRRCI (f3=111) 0x80; op2 = zero-extended instr[19:15].
- Any other encoding, including wrong f7: sel=0x00, op1=op2=0, illegal_o=1. It still flows through the buffer. Otherwise illegal_o=0.
- Handshake:
  - Input accepted when valid_i && ready_o.
  - Output entry consumed when valid_o && ready_i.
  - ready_o = !skid_valid, driven directly from a register.
  - While valid_o=1 and ready_i=0, output fields hold stable.
- Buffering:
  - Accepted instruction goes to the output register if it is empty or being consumed this cycle; otherwise it goes to the skid register.
  - When the output is consumed and the skid is valid, the skid moves to the output and any new accept goes to the skid.
  - Order is strictly preserved.
- Latency is 1 cycle: accept at edge N gives valid_o=1 after edge N. Throughput is 1 per cycle while ready_i=1.
- Full: both entries valid -> ready_o=0. Upstream must hold instr_i; no entry is overwritten.
- Flush: flush_i=1 clears both valid bits at the edge. An input accepted in the same cycle is dropped. valid_o=0 and ready_o=1 the next cycle.
- Reset (asynchronous assert, synchronous deassert upstream):
  - valid_o=0, ready_o=1, op1_o=op2_o=0, sel_o=0, rd_o=0, csr_addr_o=0, illegal_o=0.
  - Reset mid-transfer discards all entries.

Test Plan:
- After reset, ADD-free stream: AND x3,x1,x2, with rs1=0xF0F0_1234 and rs2=0x0FF0_FFFF, ready_i=1 -> one cycle later valid_o=1, sel=0x01, op1=0xF0F0_1234, op2=0x0FF0_FFFF, rd=3.
- SRAI x5,x6,4 (instr 0x40435293) with rs1=0x8000_0000 -> sel=0x10, op2=0x0000_0004. XORI with imm 0xFFF -> op2=0xFFFF_FFFF, sel=0x20.
- CSRRCI mstatus with zimm=8 (instr 0x30047073), csr_rdata=0x0000_1888 -> sel=0x80, op1=0x1888, op2=0x8, csr_addr=0x300.
- ADD x1,x2,x3 (instr 0x003100B3) and SRA with f7=0 f3=100 mis-encoded -> sel=0x00, illegal_o=1, operands 0.
- Backpressure:
  - ready_i=0, three back-to-back valid_i -> the first two are accepted and ready_o=0 on the cycle after the second.
  - Outputs hold the first entry.
  - Raise ready_i -> entries 1, 2, 3 emerge in order on consecutive cycles.
- With two entries buffered, pulse flush_i together with valid_i -> next cycle valid_o=0, ready_o=1, and the flushed instruction is never emitted. Assert rst_n_i=0 mid-stream -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/logic_issue_stage.sv
// Issue stage for the integer logic unit: decodes RV32I logic/shift/CSR-set-clear
// instructions into an operand pair plus one-hot select, buffered in a 2-entry skid buffer.
module logic_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [WIDTH-1:0] csr_rdata_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] op1_o,
  output logic [WIDTH-1:0] op2_o,
  output logic [7:0]       sel_o,
  output logic [4:0]       rd_o,
  output logic [11:0]      csr_addr_o,
  output logic             illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [7:0]       sel;
    logic [4:0]       rd;
    logic [11:0]      csr_addr;
    logic             illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  entry_t     dec;

  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] shamt_zext;
  logic [WIDTH-1:0] zimm_zext;

  assign opcode     = instr_i[6:0];
  assign f3         = instr_i[14:12];
  assign f7         = instr_i[31:25];
  assign imm_sext   = {{(WIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign shamt_zext = {{(WIDTH-5){1'b0}}, instr_i[24:20]};
  assign zimm_zext  = {{(WIDTH-5){1'b0}}, instr_i[19:15]};

  // Operands and select stay zero unless a supported encoding matches below.
  always_comb begin
    dec          = '0;
    dec.rd       = instr_i[11:7];
    dec.csr_addr = instr_i[31:20];
    dec.illegal  = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b111:  dec.sel = 8'h01;
            3'b110:  dec.sel = 8'h02;
            3'b001:  dec.sel = 8'h04;
            3'b101:  dec.sel = 8'h08;
            3'b100:  dec.sel = 8'h20;
            default: dec.sel = 8'h00;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.sel = 8'h10;
        end
        if (dec.sel != 8'h00) begin
          dec.op1 = rs1_data_i;
          dec.op2 = rs2_data_i;
        end
      end
      OPC_OP_IMM: begin
        case (f3)
          3'b111: begin dec.sel = 8'h01; dec.op2 = imm_sext; end
          3'b110: begin dec.sel = 8'h02; dec.op2 = imm_sext; end
          3'b100: begin dec.sel = 8'h20; dec.op2 = imm_sext; end
          3'b001: if (f7 == 7'b0000000) begin dec.sel = 8'h04; dec.op2 = shamt_zext; end
          3'b101: begin
            if (f7 == 7'b0000000)      begin dec.sel = 8'h08; dec.op2 = shamt_zext; end
            else if (f7 == 7'b0100000) begin dec.sel = 8'h10; dec.op2 = shamt_zext; end
          end
          default: dec.sel = 8'h00;
        endcase
        if (dec.sel != 8'h00) dec.op1 = rs1_data_i;
      end
      OPC_SYSTEM: begin
        case (f3)
          3'b010: begin dec.sel = 8'h40; dec.op2 = rs1_data_i; end
          3'b011: begin dec.sel = 8'h80; dec.op2 = rs1_data_i; end
          3'b110: begin dec.sel = 8'h40; dec.op2 = zimm_zext; end
          3'b111: begin dec.sel = 8'h80; dec.op2 = zimm_zext; end
          default: dec.sel = 8'h00;
        endcase
        if (dec.sel != 8'h00) dec.op1 = csr_rdata_i;
      end
      default: dec.sel = 8'h00;
    endcase
    if (dec.sel != 8'h00) dec.illegal = 1'b0;
  end

  // Handshake: a transfer happens on a side when its valid and ready are both high
  // at the rising edge; ready_o is the inverse of the skid-valid register.
  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, consume;

  assign ready_o = ~skid_valid_q;
  assign accept  = valid_i & ready_o;
  assign consume = out_valid_q & ready_i;

  // A full skid implies ready_o=0, so no accept can coincide with skid->out promotion.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign valid_o    = out_valid_q;
  assign op1_o      = out_q.op1;
  assign op2_o      = out_q.op2;
  assign sel_o      = out_q.sel;
  assign rd_o       = out_q.rd;
  assign csr_addr_o = out_q.csr_addr;
  assign illegal_o  = out_q.illegal;

endmodule
